// File: rtl/tr_sequencer_pkg.sv
// ============================================================================
//  Module   : nexrig_pkg
//  Purpose  : Shared types and helpers for the T/R sequencer (state encoding,
//             band one-hot constants, one-hot check).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package nexrig_pkg;

    localparam int BAND_W = 8;

    // Band PIN-diode one-hot codes
    localparam logic [BAND_W-1:0] BAND_160M = 8'h01;
    localparam logic [BAND_W-1:0] BAND_80M  = 8'h02;
    localparam logic [BAND_W-1:0] BAND_40M  = 8'h04;
    localparam logic [BAND_W-1:0] BAND_30M  = 8'h08;
    localparam logic [BAND_W-1:0] BAND_20M  = 8'h10;
    localparam logic [BAND_W-1:0] BAND_17M  = 8'h20;
    localparam logic [BAND_W-1:0] BAND_15M  = 8'h40;
    localparam logic [BAND_W-1:0] BAND_10M  = 8'h80;

    typedef enum logic [2:0] {
        RX_IDLE     = 3'd0,
        BAND_SWITCH = 3'd1,
        TX_SWITCH   = 3'd2,
        TX_ON       = 3'd3,
        TX_DRAIN    = 3'd4
    } trState_t;

    // Exactly one bit set (zero and multi-bit codes are both rejected)
    function automatic logic isOneHot(input logic [BAND_W-1:0] value);
        return (value != '0) && ((value & (value - BAND_W'(1))) == '0);
    endfunction

endpackage

`default_nettype wire

// File: rtl/tr_sequencer_if.sv
// ============================================================================
//  Module   : tr_sequencer_if
//  Purpose  : Request/response bundle between the SPI register file (master)
//             and the T/R sequencer (slave).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface tr_sequencer_if;
    import nexrig_pkg::*;

    logic              pllLocked;
    logic              pttReq;
    logic [BAND_W-1:0] bandReq;
    logic              bandLoad;
    logic              txEnable;
    logic              ncoEnable;
    logic [BAND_W-1:0] bandSelect;
    logic              busy;
    logic              bandReject;
    logic              txTimeout;

    modport master (
        output pllLocked, pttReq, bandReq, bandLoad,
        input  txEnable, ncoEnable, bandSelect, busy, bandReject, txTimeout
    );

    modport slave (
        input  pllLocked, pttReq, bandReq, bandLoad,
        output txEnable, ncoEnable, bandSelect, busy, bandReject, txTimeout
    );

endinterface

`default_nettype wire

// File: rtl/tr_sequencer_dwell_timer.sv
// ============================================================================
//  Module   : dwell_timer
//  Purpose  : Loadable down-counter that parks at zero; o_zero flags the last
//             cycle of a dwell started by loading N-1.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dwell_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rstN,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_loadValue,
    output logic             o_zero
);

    logic [WIDTH-1:0] r_count;

    // Load on request, otherwise count down and hold at zero
    always_ff @(posedge clk) begin
        if (!rstN) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_loadValue;
        end else if (r_count != '0) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    assign o_zero = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/tr_sequencer.sv
// ============================================================================
//  Module   : tr_sequencer
//  Purpose  : Break-before-make TX/RX sequencing of the T/R switch, band PIN
//             diodes and NCO/PA drive. Band changes are only taken in RX.
//             Optional TX_ON dwell limit enabled by defining TR_TX_TIMEOUT_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tr_sequencer
    import nexrig_pkg::*;
#(
    parameter int                SWITCH_SETTLE_CYC = 1000,
    parameter int                RF_DECAY_CYC      = 500,
    parameter int                BAND_SETTLE_CYC   = 2000,
    parameter logic [BAND_W-1:0] BAND_RESET        = 8'h01
`ifdef TR_TX_TIMEOUT_EN
    ,
    parameter logic [32:0]       TX_TIMEOUT_CYC    = 33'd6_000_000_000
`endif
) (
    input  logic           clk,
    input  logic           rstN,
    tr_sequencer_if.slave  bus
);

    localparam int c_MAX_DWELL =
        (SWITCH_SETTLE_CYC > RF_DECAY_CYC)
            ? ((SWITCH_SETTLE_CYC > BAND_SETTLE_CYC) ? SWITCH_SETTLE_CYC : BAND_SETTLE_CYC)
            : ((RF_DECAY_CYC > BAND_SETTLE_CYC) ? RF_DECAY_CYC : BAND_SETTLE_CYC);
    localparam int c_DWELL_W = $clog2(c_MAX_DWELL) + 1;

    trState_t               r_state;
    trState_t               w_nextState;
    logic                   w_dwellLoad;
    logic [c_DWELL_W-1:0]   w_dwellValue;
    logic                   w_dwellZero;
    logic                   w_bandAccept;
    logic                   w_txRelease;
    logic                   w_txBlocked;
    logic                   w_timeoutZero;
    logic                   w_timeoutHit;

    logic                   r_txEnable;
    logic                   r_ncoEnable;
    logic [BAND_W-1:0]      r_bandSelect;
    logic                   r_busy;
    logic                   r_bandReject;

    // Operator un-key or loss of lock both force the RF chain back to RX
    assign w_txRelease = !bus.pttReq || !bus.pllLocked;

    // Shared dwell for BAND_SWITCH, TX_SWITCH and TX_DRAIN
    dwell_timer #(
        .WIDTH (c_DWELL_W)
    ) u_dwell (
        .clk         (clk),
        .rstN        (rstN),
        .i_load      (w_dwellLoad),
        .i_loadValue (w_dwellValue),
        .o_zero      (w_dwellZero)
    );

`ifdef TR_TX_TIMEOUT_EN
    logic r_txTimeout;

    // TX_ON dwell limit, restarted on every entry to TX_ON
    dwell_timer #(
        .WIDTH (33)
    ) u_txTimer (
        .clk         (clk),
        .rstN        (rstN),
        .i_load      ((w_nextState == TX_ON) && (r_state != TX_ON)),
        .i_loadValue (TX_TIMEOUT_CYC - 33'd1),
        .o_zero      (w_timeoutZero)
    );

    // Sticky timeout flag; cleared only once the operator un-keys in RX
    always_ff @(posedge clk) begin
        if (!rstN) begin
            r_txTimeout <= 1'b0;
        end else if (w_timeoutHit) begin
            r_txTimeout <= 1'b1;
        end else if ((r_state == RX_IDLE) && !bus.pttReq) begin
            r_txTimeout <= 1'b0;
        end
    end

    assign w_txBlocked   = r_txTimeout;
    assign bus.txTimeout = r_txTimeout;
`else
    assign w_timeoutZero = 1'b0;
    assign w_txBlocked   = 1'b0;
    assign bus.txTimeout = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!rstN) begin
            r_state <= RX_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state decode plus dwell reload on every state change
    always_comb begin
        w_nextState  = r_state;
        w_dwellLoad  = 1'b0;
        w_dwellValue = '0;
        w_bandAccept = 1'b0;
        w_timeoutHit = 1'b0;

        case (r_state)
            RX_IDLE: begin
                if (bus.bandLoad) begin
                    // A rejected band request still consumes the cycle
                    if (isOneHot(bus.bandReq)) begin
                        w_bandAccept = 1'b1;
                        w_nextState  = BAND_SWITCH;
                    end
                end else if (bus.pttReq && bus.pllLocked && !w_txBlocked) begin
                    w_nextState = TX_SWITCH;
                end
            end
            BAND_SWITCH: begin
                if (w_dwellZero) begin
                    w_nextState = RX_IDLE;
                end
            end
            TX_SWITCH: begin
                if (w_txRelease) begin
                    w_nextState = TX_DRAIN;
                end else if (w_dwellZero) begin
                    w_nextState = TX_ON;
                end
            end
            TX_ON: begin
                if (w_txRelease) begin
                    w_nextState = TX_DRAIN;
                end else if (w_timeoutZero) begin
                    w_nextState  = TX_DRAIN;
                    w_timeoutHit = 1'b1;
                end
            end
            TX_DRAIN: begin
                if (w_dwellZero) begin
                    w_nextState = RX_IDLE;
                end
            end
            default: begin
                w_nextState = RX_IDLE;
            end
        endcase

        if (w_nextState != r_state) begin
            w_dwellLoad = 1'b1;
            case (w_nextState)
                BAND_SWITCH: w_dwellValue = c_DWELL_W'(BAND_SETTLE_CYC - 1);
                TX_SWITCH:   w_dwellValue = c_DWELL_W'(SWITCH_SETTLE_CYC - 1);
                TX_DRAIN:    w_dwellValue = c_DWELL_W'(RF_DECAY_CYC - 1);
                default:     w_dwellValue = '0;
            endcase
        end
    end

    // Outputs registered from the next state so they change with the state
    always_ff @(posedge clk) begin
        if (!rstN) begin
            r_txEnable   <= 1'b0;
            r_ncoEnable  <= 1'b0;
            r_bandSelect <= BAND_RESET;
            r_busy       <= 1'b0;
            r_bandReject <= 1'b0;
        end else begin
            r_txEnable   <= (w_nextState == TX_SWITCH) || (w_nextState == TX_ON) ||
                            (w_nextState == TX_DRAIN);
            r_ncoEnable  <= (w_nextState == TX_ON);
            r_busy       <= (w_nextState != RX_IDLE);
            r_bandReject <= bus.bandLoad && !w_bandAccept;
            if (w_bandAccept) begin
                r_bandSelect <= bus.bandReq;
            end
        end
    end

    assign bus.txEnable   = r_txEnable;
    assign bus.ncoEnable  = r_ncoEnable;
    assign bus.bandSelect = r_bandSelect;
    assign bus.busy       = r_busy;
    assign bus.bandReject = r_bandReject;

endmodule

`default_nettype wire

// File: tb/tb_tr_sequencer.sv
// ============================================================================
//  Module   : tb_tr_sequencer
//  Purpose  : Self-checking bench for tr_sequencer (vector table, directed
//             sequences, random stimulus against a timestamp-based model).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tr_sequencer;

    localparam int SW = 4;
    localparam int RF = 3;
    localparam int BS = 5;
    localparam int TO = 20;

    localparam int M_IDLE  = 0;
    localparam int M_BAND  = 1;
    localparam int M_SW    = 2;
    localparam int M_ON    = 3;
    localparam int M_DRAIN = 4;

    logic clk;
    logic rstN;
    int   nChk;
    int   nErr;

    tr_sequencer_if ifc ();

    tr_sequencer #(
        .SWITCH_SETTLE_CYC (SW),
        .RF_DECAY_CYC      (RF),
        .BAND_SETTLE_CYC   (BS),
        .BAND_RESET        (8'h01)
`ifdef TR_TX_TIMEOUT_EN
        ,
        .TX_TIMEOUT_CYC    (33'd20)
`endif
    ) dut (
        .clk  (clk),
        .rstN (rstN),
        .bus  (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model: modes with entry timestamps ----------
    int         edgeNo;
    int         mMode;
    int         mEnter;
    logic [7:0] mBand;
    logic       mRej;
    logic       mTo;

    function automatic void enterMode(input int m);
        mMode  = m;
        mEnter = edgeNo;
    endfunction

    task automatic modelStep(input logic r, input logic p, input logic l,
                             input logic [7:0] req, input logic ld);
        int elapsed;
        bit okBand;
        edgeNo++;
        if (!r) begin
            mBand = 8'h01;
            mRej  = 1'b0;
            mTo   = 1'b0;
            enterMode(M_IDLE);
            return;
        end
        elapsed = edgeNo - mEnter;
        okBand  = ($countones(req) == 1);
        mRej    = ld && !(mMode == M_IDLE && okBand);
        if (mMode == M_IDLE && !p) mTo = 1'b0;
        case (mMode)
            M_IDLE: begin
                if (ld) begin
                    if (okBand) begin
                        mBand = req;
                        enterMode(M_BAND);
                    end
                end else if (p && l && !mTo) begin
                    enterMode(M_SW);
                end
            end
            M_BAND:  if (elapsed >= BS) enterMode(M_IDLE);
            M_SW: begin
                if (!p || !l) enterMode(M_DRAIN);
                else if (elapsed >= SW) enterMode(M_ON);
            end
            M_ON: begin
                if (!p || !l) enterMode(M_DRAIN);
`ifdef TR_TX_TIMEOUT_EN
                else if (elapsed >= TO) begin
                    enterMode(M_DRAIN);
                    mTo = 1'b1;
                end
`endif
            end
            default: if (elapsed >= RF) enterMode(M_IDLE);
        endcase
    endtask

    // {txEnable, ncoEnable, bandSelect, busy, bandReject, txTimeout}
    function automatic logic [12:0] modelOut();
        logic tx;
        tx = (mMode == M_SW) || (mMode == M_ON) || (mMode == M_DRAIN);
        return {tx, mMode == M_ON, mBand, mMode != M_IDLE, mRej, mTo};
    endfunction

    function automatic logic [12:0] dutOut();
        return {ifc.txEnable, ifc.ncoEnable, ifc.bandSelect, ifc.busy,
                ifc.bandReject, ifc.txTimeout};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChk++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Drive inputs away from the edge, clock once, step model, sample after
    task automatic tick(input logic r, input logic p, input logic l,
                        input logic [7:0] req, input logic ld);
        rstN          = r;
        ifc.pttReq    = p;
        ifc.pllLocked = l;
        ifc.bandReq   = req;
        ifc.bandLoad  = ld;
        @(posedge clk);
        modelStep(r, p, l, req, ld);
        #1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic       r, p, l;
        logic [7:0] req;
        logic       ld;
        logic       tx, nco;
        logic [7:0] band;
        logic       busy, rej;
    } vec_t;

    vec_t tbl[$];

    function automatic void addRow(input logic r, input logic p, input logic l,
                                   input logic [7:0] req, input logic ld,
                                   input logic tx, input logic nco, input logic [7:0] band,
                                   input logic busy, input logic rej);
        vec_t v;
        v.r = r; v.p = p; v.l = l; v.req = req; v.ld = ld;
        v.tx = tx; v.nco = nco; v.band = band; v.busy = busy; v.rej = rej;
        tbl.push_back(v);
    endfunction

    logic       pttSeq [11] = '{1, 1, 0, 1, 1, 1, 1, 0, 0, 0, 0};
    logic [2:0] expSeq [11] = '{3'b101, 3'b101, 3'b101, 3'b101, 3'b101, 3'b000,
                                3'b101, 3'b101, 3'b101, 3'b101, 3'b000};

    initial begin
        logic [12:0] o;
        logic [2:0]  e3;
        logic        rr, rp, rl, rld;
        logic [7:0]  rreq;

        nChk = 0; nErr = 0; edgeNo = 0;
        mMode = M_IDLE; mEnter = 0; mBand = 8'h01; mRej = 1'b0; mTo = 1'b0;

        // rows: r p l req ld | tx nco band busy rej
        addRow(0, 0, 1, 8'h00, 0,  0, 0, 8'h01, 0, 0);
        addRow(1, 0, 1, 8'h00, 0,  0, 0, 8'h01, 0, 0);
        addRow(1, 0, 1, 8'h00, 1,  0, 0, 8'h01, 0, 1);
        addRow(1, 0, 1, 8'h06, 1,  0, 0, 8'h01, 0, 1);
        addRow(1, 0, 1, 8'h06, 0,  0, 0, 8'h01, 0, 0);
        addRow(1, 0, 1, 8'h04, 1,  0, 0, 8'h04, 1, 0);
        for (int i = 0; i < 4; i++) addRow(1, 0, 1, 8'h00, 0,  0, 0, 8'h04, 1, 0);
        addRow(1, 0, 1, 8'h00, 0,  0, 0, 8'h04, 0, 0);
        addRow(1, 1, 1, 8'h08, 1,  0, 0, 8'h08, 1, 0);
        for (int i = 0; i < 4; i++) addRow(1, 1, 1, 8'h00, 0,  0, 0, 8'h08, 1, 0);
        addRow(1, 1, 1, 8'h00, 0,  0, 0, 8'h08, 0, 0);
        for (int i = 0; i < 4; i++) addRow(1, 1, 1, 8'h00, 0,  1, 0, 8'h08, 1, 0);
        addRow(1, 1, 1, 8'h00, 0,  1, 1, 8'h08, 1, 0);
        addRow(1, 1, 1, 8'h01, 1,  1, 1, 8'h08, 1, 1);
        addRow(1, 1, 1, 8'h00, 0,  1, 1, 8'h08, 1, 0);
        for (int i = 0; i < 3; i++) addRow(1, 1, 0, 8'h00, 0,  1, 0, 8'h08, 1, 0);
        addRow(1, 1, 0, 8'h00, 0,  0, 0, 8'h08, 0, 0);
        addRow(1, 0, 1, 8'h00, 0,  0, 0, 8'h08, 0, 0);

        foreach (tbl[i]) begin
            tick(tbl[i].r, tbl[i].p, tbl[i].l, tbl[i].req, tbl[i].ld);
            chk($sformatf("row%0d", i), 32'(dutOut()),
                32'({tbl[i].tx, tbl[i].nco, tbl[i].band, tbl[i].busy, tbl[i].rej, 1'b0}));
        end

        // Key at edge 10, unkey at edge 30 (edges counted after a reset)
        tick(0, 0, 1, 8'h00, 0);
        for (int c = 1; c <= 40; c++) begin
            tick(1, (c >= 10 && c < 30), 1, 8'h00, 0);
            e3 = {(c >= 10 && c <= 32), (c >= 14 && c <= 29), (c >= 10 && c <= 32)};
            chk($sformatf("keyUnkey_c%0d", c),
                32'({ifc.txEnable, ifc.ncoEnable, ifc.busy}), 32'(e3));
        end

        // Abort during TX_SWITCH; re-key during drain is ignored
        for (int i = 0; i < 11; i++) begin
            tick(1, pttSeq[i], 1, 8'h00, 0);
            chk($sformatf("abort%0d", i),
                32'({ifc.txEnable, ifc.ncoEnable, ifc.busy}), 32'(expSeq[i]));
        end

        // Reset while in TX_ON with a non-default band selected
        tick(1, 0, 1, 8'h20, 1);
        for (int i = 0; i < BS; i++) tick(1, 0, 1, 8'h00, 0);
        for (int i = 0; i <= SW; i++) tick(1, 1, 1, 8'h00, 0);
        chk("midTxOn", 32'({ifc.ncoEnable, ifc.bandSelect}), 32'({1'b1, 8'h20}));
        tick(0, 1, 1, 8'h00, 0);
        chk("midTxReset", 32'(dutOut()), 32'({1'b0, 1'b0, 8'h01, 1'b0, 1'b0, 1'b0}));
        tick(1, 0, 1, 8'h00, 0);

`ifdef TR_TX_TIMEOUT_EN
        // Held key: TX_ON limited to TO cycles, re-key blocked until un-key
        for (int i = 0; i < 36; i++) begin
            tick(1, 1, 1, 8'h00, 0);
            e3 = {(i <= SW + TO + RF - 1), (i >= SW && i < SW + TO), (i >= SW + TO)};
            chk($sformatf("timeout%0d", i),
                32'({ifc.txEnable, ifc.ncoEnable, ifc.txTimeout}), 32'(e3));
        end
        tick(1, 0, 1, 8'h00, 0);
        chk("timeoutClear", 32'({ifc.txEnable, ifc.txTimeout}), 32'(2'b00));
        tick(1, 1, 1, 8'h00, 0);
        chk("rekeyAfterClear", 32'({ifc.txEnable, ifc.txTimeout}), 32'(2'b10));
        for (int i = 0; i < 5; i++) tick(1, 0, 1, 8'h00, 0);
`endif

        // Random stimulus against the model
        rp = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            rr   = ($urandom_range(0, 399) != 0);
            if ($urandom_range(0, 24) == 0) rp = ~rp;
            rl   = ($urandom_range(0, 59) != 0);
            rld  = ($urandom_range(0, 14) == 0);
            rreq = $urandom_range(0, 1) ? 8'(1 << $urandom_range(0, 7)) : 8'($urandom);
            tick(rr, rp, rl, rreq, rld);
            o = dutOut();
            chk($sformatf("rand%0d", n), 32'(o), 32'(modelOut()));
            if (o[11] && !o[12]) chk($sformatf("ncoImpliesTx%0d", n), 32'(o[12]), 32'(1));
        end

        $display("Result: errors=%0d of %0d checks", nErr, nChk);
        $finish;
    end

endmodule

`default_nettype wire
